// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package arm_mem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_e;

   // req_size encodings
   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   // CPU byte address of data RAM byte 0
   localparam logic [31:0] DATA_BASE = 32'd1024;

endpackage

// File: rtl/arm_byte_ram.sv
// Single-port byte-wide data RAM: synchronous write, asynchronous read.
module arm_byte_ram #(
   parameter int unsigned DEPTH     = 1024,
   parameter string       INIT_FILE = "",
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Write port; the array has no reset by design
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder: serialises CPU loads/stores into big-endian byte accesses.
module arm_mem_responder
   import arm_mem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = DATA_BASE,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e        state_q, state_d;
   logic          we_q;
   logic          size_q;
   logic [AW-1:0] off_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [1:0]    cnt_q;
   logic [1:0]    last_q;

   logic [31:0]   req_off;
   logic          req_err;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   // Address check, evaluated on the incoming request at accept
   always_comb begin
      req_off = req_addr - BASE_ADDR;
      req_err = (req_addr < BASE_ADDR);
      if (req_size == SIZE_WORD) begin
         req_err = req_err || (req_off > 32'(DEPTH - 4)) || (req_addr[1:0] != 2'b00);
      end else begin
         req_err = req_err || (req_off > 32'(DEPTH - 1));
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid) state_d = req_err ? RESP : XFER;
         XFER:    if (cnt_q == last_q) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs and RAM port drive
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      // Gate with reset so an aborted store leaves the current byte untouched
      ram_we    = (state_q == XFER) && we_q && reset_n;
      ram_addr  = off_q + AW'(cnt_q);
      ram_wdata = wdata_q[7:0];
      if (size_q == SIZE_WORD) begin
         unique case (cnt_q)
            2'd0: ram_wdata = wdata_q[31:24];
            2'd1: ram_wdata = wdata_q[23:16];
            2'd2: ram_wdata = wdata_q[15:8];
            2'd3: ram_wdata = wdata_q[7:0];
            default: ram_wdata = wdata_q[7:0];
         endcase
      end
   end

   // Request capture, byte counter and load shift register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         size_q  <= SIZE_BYTE;
         off_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  off_q   <= req_off[AW-1:0];
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= req_err;
                  cnt_q   <= 2'd0;
                  last_q  <= (req_size == SIZE_WORD) ? 2'd3 : 2'd0;
               end
            end
            XFER: begin
               if (!we_q) rdata_q <= {rdata_q[23:0], ram_rdata};
               if (cnt_q != last_q) cnt_q <= cnt_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   arm_byte_ram #(
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed self-checking bench for arm_mem_responder.
module tb_arm_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fails  = 0;

   arm_mem_responder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge, accept it, then wait for the response.
   // Latency counts negedges after the accept edge until rsp_valid is seen.
   task automatic issue(input logic we, input logic size, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
      @(negedge clk);
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      chk({"req_ready idle ", $sformatf("%h", addr)}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
   endtask

   task automatic xact(input string tag, input logic we, input logic size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int lat;
      issue(we, size, addr, wdata, lat);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata, exp_rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int lat;
      logic [31:0] held;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      reset_n = 1'b1;

      // Word store then loads, byte load, byte store merge
      xact("st w 400", 1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0, 1'b0, 5);
      xact("ld w 400", 1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBEEF, 1'b0, 5);
      xact("ld b 400", 1'b0, 1'b0, 32'h400, 32'h0, 32'h000000DE, 1'b0, 2);
      xact("ld b 402", 1'b0, 1'b0, 32'h402, 32'h0, 32'h000000BE, 1'b0, 2);
      xact("st b 403", 1'b1, 1'b0, 32'h403, 32'hFFFFFF55, 32'h0, 1'b0, 2);
      xact("ld w 400b", 1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBE55, 1'b0, 5);

      // Faults: misaligned, out of range, below base; stores must not write
      xact("err ld w 401", 1'b0, 1'b1, 32'h401, 32'h0, 32'h0, 1'b1, 1);
      xact("err ld w 7FE", 1'b0, 1'b1, 32'h7FE, 32'h0, 32'h0, 1'b1, 1);
      xact("err ld b 3FF", 1'b0, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b1, 1);
      xact("err st w 402", 1'b1, 1'b1, 32'h402, 32'h12345678, 32'h0, 1'b1, 1);
      xact("err st b 800", 1'b1, 1'b0, 32'h800, 32'h00000077, 32'h0, 1'b1, 1);
      xact("err st b 3FF", 1'b1, 1'b0, 32'h3FF, 32'h00000077, 32'h0, 1'b1, 1);
      xact("ld w 400c", 1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBE55, 1'b0, 5);

      // Top-of-RAM boundaries: last word and last byte are legal
      xact("st w 7FC", 1'b1, 1'b1, 32'h7FC, 32'h01020304, 32'h0, 1'b0, 5);
      xact("ld w 7FC", 1'b0, 1'b1, 32'h7FC, 32'h0, 32'h01020304, 1'b0, 5);
      xact("ld b 7FF", 1'b0, 1'b0, 32'h7FF, 32'h0, 32'h00000004, 1'b0, 2);

      // Response backpressure with spurious requests
      issue(1'b0, 1'b1, 32'h400, 32'h0, lat);
      chk("bp latency", 32'(lat), 32'd5);
      held = rsp_rdata;
      chk("bp rdata", held, 32'hDEADBE55);
      for (int i = 0; i < 10; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_size  = 1'b1;
         req_addr  = 32'h400;
         req_wdata = 32'h99999999;
         @(posedge clk);
         #1 req_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("bp rsp_valid %0d", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp rdata %0d", i), rsp_rdata, 32'hDEADBE55);
         chk($sformatf("bp err %0d", i), 32'(rsp_err), 32'd0);
         chk($sformatf("bp req_ready %0d", i), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp release", 32'(rsp_valid), 32'd0);
      xact("ld w 400d", 1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBE55, 1'b0, 5);

      // Reset mid-store: bytes 0..1 land, bytes 2..3 keep old contents
      xact("st w 404", 1'b1, 1'b1, 32'h404, 32'hCAFEF00D, 32'h0, 1'b0, 5);
      xact("ld w 404", 1'b0, 1'b1, 32'h404, 32'h0, 32'hCAFEF00D, 1'b0, 5);
      @(negedge clk);
      req_we    = 1'b1;
      req_size  = 1'b1;
      req_addr  = 32'h404;
      req_wdata = 32'h11223344;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort req_ready", 32'(req_ready), 32'd1);
      chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort rsp_rdata", rsp_rdata, 32'd0);
      chk("abort rsp_err", 32'(rsp_err), 32'd0);
      reset_n = 1'b1;
      xact("ld w 404b", 1'b0, 1'b1, 32'h404, 32'h0, 32'h1122F00D, 1'b0, 5);
      xact("ld w 400e", 1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBE55, 1'b0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
